shift_arbiter: RTL and testbench

//   Sequencer/arbiter sharing one combinational 16-bit barrel shifter (SLL/SRA) between
//   two requesters (e.g. ALU issue and address-gen). Round-robin grant, valid/ready in,

---
 rtl/shift_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_shift_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sequencer sharing one external 16-bit barrel
// shifter (SLL/SRA) between two requesters; adds ROR via two shifter passes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   reqN_valid/ready    request handshake (N = 0, 1); ready goes only to the winner
//   reqN_data/amt/op    operand, shift amount, op (00 SLL, 01 SRA, 10 ROR, 11 rsvd)
//   resp_valid/ready    result handshake; result held until taken
//   resp_id/data/err    owner, result, reserved-op flag
//   sh_in/sh_val/sh_mode  drive the shared shifter (mode 0 SLL, 1 SRA)
//   sh_out              combinational shifter result
module shift_arbiter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic [WIDTH-1:0] sh_in,
  output logic [AMT_W-1:0] sh_val,
  output logic             sh_mode,
  input  logic [WIDTH-1:0] sh_out
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS1,
    S_PASS2,
    S_RESP
  } state_e;

  state_e           state_q;
  logic             rr_ptr_q;
  logic             id_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] amt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] tmp_q;

  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_err_q;
  logic [WIDTH-1:0] sh_in_q;
  logic [AMT_W-1:0] sh_val_q;
  logic             sh_mode_q;

  logic             grant;
  logic             win;
  logic [WIDTH-1:0] w_data;
  logic [AMT_W-1:0] w_amt;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] p1_in_d;
  logic [AMT_W-1:0] p1_val_d;
  logic             p1_mode_d;
  logic             ror2;
  logic [WIDTH-1:0] lo_mask;

  // Winner selection; contention resolved by rr_ptr.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) begin
      win = rr_ptr_q;
    end else if (req1_valid) begin
      win = 1'b1;
    end
    grant  = (state_q == S_IDLE) && (req0_valid || req1_valid) && !rst;
    w_data = win ? req1_data : req0_data;
    w_amt  = win ? req1_amt  : req0_amt;
    w_op   = win ? req1_op   : req0_op;
  end

  assign req0_ready = grant && !win;
  assign req1_ready = grant &&  win;

  // First-pass shifter setup, loaded at grant so sh_* are registered.
  // ROR first pass is a left shift by 16-amt (4-bit negate); amt 0
  // yields a zero shift, which already equals the rotate result.
  always_comb begin
    p1_in_d   = '0;
    p1_val_d  = '0;
    p1_mode_d = 1'b0;
    unique case (w_op)
      OP_SLL: begin
        p1_in_d  = w_data;
        p1_val_d = w_amt;
      end
      OP_SRA: begin
        p1_in_d   = w_data;
        p1_val_d  = w_amt;
        p1_mode_d = 1'b1;
      end
      OP_ROR: begin
        p1_in_d  = w_data;
        p1_val_d = -w_amt;
      end
      default: begin
        p1_in_d = '0;
      end
    endcase
  end

  assign ror2 = (op_q == OP_ROR) && (amt_q != '0);

  // Second ROR pass uses SRA; mask off the sign-extended upper bits
  // so it behaves as a logical right shift.
  assign lo_mask = {WIDTH{1'b1}} >> amt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= 1'b0;
      id_q         <= 1'b0;
      data_q       <= '0;
      amt_q        <= '0;
      op_q         <= '0;
      tmp_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      sh_in_q      <= '0;
      sh_val_q     <= '0;
      sh_mode_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (grant) begin
            id_q      <= win;
            data_q    <= w_data;
            amt_q     <= w_amt;
            op_q      <= w_op;
            rr_ptr_q  <= ~win;
            sh_in_q   <= p1_in_d;
            sh_val_q  <= p1_val_d;
            sh_mode_q <= p1_mode_d;
            state_q   <= S_PASS1;
          end
        end
        S_PASS1: begin
          if (op_q == 2'b11) begin
            resp_data_q  <= data_q;
            resp_err_q   <= 1'b1;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            sh_in_q      <= '0;
            sh_val_q     <= '0;
            sh_mode_q    <= 1'b0;
            state_q      <= S_RESP;
          end else if (ror2) begin
            tmp_q     <= sh_out;
            sh_val_q  <= amt_q;
            sh_mode_q <= 1'b1;
            state_q   <= S_PASS2;
          end else begin
            resp_data_q  <= sh_out;
            resp_err_q   <= 1'b0;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            sh_in_q      <= '0;
            sh_val_q     <= '0;
            sh_mode_q    <= 1'b0;
            state_q      <= S_RESP;
          end
        end
        S_PASS2: begin
          resp_data_q  <= tmp_q | (sh_out & lo_mask);
          resp_err_q   <= 1'b0;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          sh_in_q      <= '0;
          sh_val_q     <= '0;
          sh_mode_q    <= 1'b0;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign sh_in      = sh_in_q;
  assign sh_val     = sh_val_q;
  assign sh_mode    = sh_mode_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed vectors plus handshake, arbitration
// and reset-abort sequences for shift_arbiter with a behavioural shifter.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amt, req1_amt;
  logic [1:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [15:0] resp_data;
  logic [15:0] sh_in, sh_out;
  logic [3:0]  sh_val;
  logic        sh_mode;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Reference shared shifter.
  assign sh_out = sh_mode ? 16'($signed(sh_in) >>> sh_val)
                          : 16'(sh_in << sh_val);

  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_amt(req1_amt), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .sh_in(sh_in), .sh_val(sh_val), .sh_mode(sh_mode), .sh_out(sh_out)
  );

  typedef struct {
    logic        rid;
    logic [15:0] data;
    logic [3:0]  amt;
    logic [1:0]  op;
    logic [15:0] exp;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic rid, input logic v, input logic [15:0] d,
                         input logic [3:0] a, input logic [1:0] o);
    if (rid) begin
      req1_valid = v; req1_data = d; req1_amt = a; req1_op = o;
    end else begin
      req0_valid = v; req0_data = d; req0_amt = a; req0_op = o;
    end
  endtask

  task automatic wait_ready(input logic rid, output bit ok);
    int n = 0;
    while (!(rid ? req1_ready : req0_ready) && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    ok = (n < 10);
    chk("grant_wait_bound", 32'(ok), 32'd1);
  endtask

  // Called the cycle after grant; returns cycles from grant to resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_wait_bound", 32'(resp_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit ok;
    int lat;
    logic gid;

    vecs[0]  = '{1'b0, 16'h0001, 4'd4,  2'b00, 16'h0010, 1'b0, 2};
    vecs[1]  = '{1'b1, 16'h8000, 4'd15, 2'b01, 16'hFFFF, 1'b0, 2};
    vecs[2]  = '{1'b1, 16'h4000, 4'd14, 2'b01, 16'h0001, 1'b0, 2};
    vecs[3]  = '{1'b0, 16'h1234, 4'd4,  2'b10, 16'h4123, 1'b0, 3};
    vecs[4]  = '{1'b1, 16'h8001, 4'd1,  2'b10, 16'hC000, 1'b0, 3};
    vecs[5]  = '{1'b0, 16'h8001, 4'd0,  2'b10, 16'h8001, 1'b0, 2};
    vecs[6]  = '{1'b0, 16'hABCD, 4'd3,  2'b11, 16'hABCD, 1'b1, 2};
    vecs[7]  = '{1'b1, 16'hFFFF, 4'd15, 2'b00, 16'h8000, 1'b0, 2};
    vecs[8]  = '{1'b0, 16'h7FFF, 4'd3,  2'b01, 16'h0FFF, 1'b0, 2};
    vecs[9]  = '{1'b1, 16'h00F0, 4'd15, 2'b10, 16'h01E0, 1'b0, 3};
    vecs[10] = '{1'b0, 16'h1234, 4'd0,  2'b00, 16'h1234, 1'b0, 2};

    rst = 1'b1;
    resp_ready = 1'b1;
    set_req(1'b0, 1'b0, 16'h0, 4'h0, 2'b00);
    set_req(1'b1, 1'b1, 16'h5555, 4'h1, 2'b00);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id",    32'(resp_id),    32'd0);
    chk("rst_resp_data",  32'(resp_data),  32'd0);
    chk("rst_resp_err",   32'(resp_err),   32'd0);
    chk("rst_sh_in",      32'(sh_in),      32'd0);
    chk("rst_sh_val",     32'(sh_val),     32'd0);
    chk("rst_sh_mode",    32'(sh_mode),    32'd0);
    set_req(1'b1, 1'b0, 16'h0, 4'h0, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // Table: single-requester operations.
    foreach (vecs[i]) begin
      @(negedge clk);
      set_req(vecs[i].rid, 1'b1, vecs[i].data, vecs[i].amt, vecs[i].op);
      #1;
      wait_ready(vecs[i].rid, ok);
      chk($sformatf("v%0d_other_ready", i),
          32'(vecs[i].rid ? req0_ready : req1_ready), 32'd0);
      @(negedge clk);
      set_req(vecs[i].rid, 1'b0, 16'h0, 4'h0, 2'b00);
      wait_resp(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_data", i), 32'(resp_data), 32'(vecs[i].exp));
      chk($sformatf("v%0d_id", i), 32'(resp_id), 32'(vecs[i].rid));
      chk($sformatf("v%0d_err", i), 32'(resp_err), 32'(vecs[i].err));
      @(negedge clk);
      chk($sformatf("v%0d_valid_drop", i), 32'(resp_valid), 32'd0);
    end

    // Both requesters continuously valid from reset: grants alternate.
    do_reset();
    set_req(1'b0, 1'b1, 16'h0001, 4'd1, 2'b00);
    set_req(1'b1, 1'b1, 16'h0001, 4'd2, 2'b00);
    #1;
    for (int g = 0; g < 4; g++) begin
      int n = 0;
      while (!(req0_ready || req1_ready) && n < 10) begin
        @(negedge clk); #1;
        n++;
      end
      chk("alt_grant_bound", 32'(n < 10), 32'd1);
      chk("alt_single_ready", 32'(req0_ready && req1_ready), 32'd0);
      gid = req1_ready;
      chk($sformatf("alt_grant%0d", g), 32'(gid), 32'(g % 2));
      @(negedge clk);
      wait_resp(lat);
      chk($sformatf("alt_resp_id%0d", g), 32'(resp_id), 32'(gid));
      chk($sformatf("alt_resp_data%0d", g), 32'(resp_data),
          gid ? 32'h0004 : 32'h0002);
      @(negedge clk); #1;
    end
    set_req(1'b0, 1'b0, 16'h0, 4'h0, 2'b00);
    set_req(1'b1, 1'b0, 16'h0, 4'h0, 2'b00);
    repeat (4) @(negedge clk);

    // Back-pressure: result held, no grant while busy.
    resp_ready = 1'b0;
    set_req(1'b1, 1'b1, 16'h8000, 4'd4, 2'b01);
    #1;
    wait_ready(1'b1, ok);
    @(negedge clk);
    set_req(1'b1, 1'b0, 16'h0, 4'h0, 2'b00);
    set_req(1'b0, 1'b1, 16'h0001, 4'd0, 2'b00);
    wait_resp(lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data",  32'(resp_data),  32'hF800);
      chk("bp_id",    32'(resp_id),    32'd1);
      chk("bp_err",   32'(resp_err),   32'd0);
      chk("bp_no_ready0", 32'(req0_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_valid_drop", 32'(resp_valid), 32'd0);
    chk("bp_next_grant", 32'(req0_ready), 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'h0, 4'h0, 2'b00);
    wait_resp(lat);
    chk("bp_follow_data", 32'(resp_data), 32'h0001);
    chk("bp_follow_id",   32'(resp_id),   32'd0);
    @(negedge clk);

    // Reset during PASS2 of a ROR aborts it and clears rr_ptr.
    set_req(1'b0, 1'b1, 16'h1234, 4'd4, 2'b10);
    #1;
    wait_ready(1'b0, ok);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'h0, 4'h0, 2'b00);
    @(negedge clk);
    chk("abort_in_pass2_mode", 32'(sh_mode), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_sh_val", 32'(sh_val), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    set_req(1'b0, 1'b1, 16'h0003, 4'd1, 2'b00);
    set_req(1'b1, 1'b1, 16'h0003, 4'd2, 2'b00);
    #1;
    chk("abort_rr0_req0", 32'(req0_ready), 32'd1);
    chk("abort_rr0_req1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'h0, 4'h0, 2'b00);
    set_req(1'b1, 1'b0, 16'h0, 4'h0, 2'b00);
    wait_resp(lat);
    chk("abort_follow_data", 32'(resp_data), 32'h0006);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
